wb_arbiter: RTL and testbench

- Write-back stage directly upstream of the register file.
- Collects results from the ALU (single-cycle producer) and the memory unit (variable-latency producer) into a DEPTH-entry in-order queue.
- Drives the register file's single write port (we3/ra3/wd3) at one write per cycle.
- Exports per-read-port pending flags so decode can stall on RAW hazards against queued writes.

---
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage in front of the register file.
// Merges ALU and memory results into an in-order queue and retires one
// entry per cycle onto the register file write port (we3/ra3/wd3).
// busy1/busy2 flag reads that still have a pending write queued or in flight.
module wb_arbiter #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              we3,
  output logic [ADDR_W-1:0] ra3,
  output logic [DATA_W-1:0] wd3,
  output logic              err_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     LP_DEPTH = CW'(DEPTH);
  localparam logic [ADDR_W:0]   LP_NREGS = (ADDR_W + 1)'(NREGS);

  // Queue storage and control state
  logic [ADDR_W-1:0] r_rd_q   [DEPTH];
  logic [DATA_W-1:0] r_data_q [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_we3;
  logic [ADDR_W-1:0] r_ra3;
  logic [DATA_W-1:0] r_wd3;
  logic              r_err;

  logic              w_mem_acc;
  logic              w_alu_acc;
  logic              w_mem_ok;
  logic              w_alu_ok;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [PW-1:0]     w_alu_slot;
  logic [CW-1:0]     w_count_plus_mem;
  logic [CW-1:0]     w_count_next;
  logic [DEPTH-1:0]  w_occ;
  logic              w_busy1;
  logic              w_busy2;

  // Readiness looks only at the registered count: a pop in the same cycle
  // earns no credit, which keeps ready off the pop path.
  assign mem_ready        = !flush && (r_count < LP_DEPTH);
  assign w_mem_acc        = mem_valid && mem_ready;
  assign w_count_plus_mem = r_count + CW'(w_mem_acc);
  assign alu_ready        = !flush && (w_count_plus_mem < LP_DEPTH);
  assign w_alu_acc        = alu_valid && alu_ready;

  // An accepted result aimed past the last architectural register completes
  // its handshake but is dropped instead of queued.
  assign w_mem_ok   = {1'b0, mem_rd} < LP_NREGS;
  assign w_alu_ok   = {1'b0, alu_rd} < LP_NREGS;
  assign w_mem_push = w_mem_acc && w_mem_ok;
  assign w_alu_push = w_alu_acc && w_alu_ok;

  // Memory is older than ALU when both land together, so ALU takes the next slot.
  assign w_alu_slot   = r_wr_ptr + PW'(w_mem_push);
  assign w_pop        = (r_count != '0);
  assign w_count_next = r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);

  // Pending-write detection over the output stage and every occupied slot
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_occ   = '0;
    w_busy1 = r_we3 && (r_ra3 == ra1);
    w_busy2 = r_we3 && (r_ra3 == ra2);
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is live when its distance from the head is below the count.
      w_occ[i] = {1'b0, PW'(i) - r_rd_ptr} < r_count;
      if (w_occ[i] && (r_rd_q[i] == ra1)) w_busy1 = 1'b1;
      if (w_occ[i] && (r_rd_q[i] == ra2)) w_busy2 = 1'b1;
    end
  end

  // Queue payload write; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; stale slots are unreachable once count/pointers clear.
    if (w_mem_push) begin
      r_rd_q[r_wr_ptr]   <= mem_rd;
      r_data_q[r_wr_ptr] <= mem_data;
    end
    if (w_alu_push) begin
      r_rd_q[w_alu_slot]   <= alu_rd;
      r_data_q[w_alu_slot] <= alu_data;
    end
  end

  // Pointers, count, registered write port and sticky address error
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_we3    <= 1'b0;
      r_ra3    <= '0;
      r_wd3    <= '0;
      r_err    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_we3    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_next;
      r_we3    <= w_pop;
      if (w_pop) begin
        r_ra3 <= r_rd_q[r_rd_ptr];
        r_wd3 <= r_data_q[r_rd_ptr];
      end
      if ((w_mem_acc && !w_mem_ok) || (w_alu_acc && !w_alu_ok)) r_err <= 1'b1;
    end
  end

  assign busy1    = w_busy1;
  assign busy2    = w_busy2;
  assign we3      = r_we3;
  assign ra3      = r_ra3;
  assign wd3      = r_wd3;
  assign err_addr = r_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic, checked against
// a queue-based reference model of the write-back stage.
module tb_wb_arbiter;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 12;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0] alu_rd, mem_rd, ra1, ra2, ra3;
  logic [DATA_W-1:0] alu_data, mem_data, wd3;
  logic              busy1, busy2, we3, err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .we3(we3), .ra3(ra3), .wd3(wd3), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Reference model: an in-order list of pending writes plus the write port
  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_q[$];
  logic              m_we  = 1'b0;
  logic [ADDR_W-1:0] m_ra  = '0;
  logic [DATA_W-1:0] m_wd  = '0;
  logic              m_err = 1'b0;

  function automatic logic f_mem_ready();
    return !flush && (m_q.size() < DEPTH);
  endfunction

  function automatic logic f_alu_ready();
    int extra;
    extra = (mem_valid && f_mem_ready()) ? 1 : 0;
    return !flush && ((m_q.size() + extra) < DEPTH);
  endfunction

  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
    if (m_we && m_ra == a) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    logic mr, ar;
    mr = f_mem_ready();
    ar = f_alu_ready();
    if (rst) begin
      m_q.delete();
      m_we = 1'b0; m_ra = '0; m_wd = '0; m_err = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_we = 1'b0;
    end else begin
      if (m_q.size() > 0) begin
        m_we = 1'b1; m_ra = m_q[0].rd; m_wd = m_q[0].data;
        void'(m_q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (mem_valid && mr) begin
        if (mem_rd < NREGS) m_q.push_back('{mem_rd, mem_data}); else m_err = 1'b1;
      end
      if (alu_valid && ar) begin
        if (alu_rd < NREGS) m_q.push_back('{alu_rd, alu_data}); else m_err = 1'b1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0; ra1 = '0; ra2 = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_cmp++; if (we3 !== 1'b0)      begin n_bad++; $display("FAIL reset_we3: got %b want 0", we3); end
    n_cmp++; if (ra3 !== '0)        begin n_bad++; $display("FAIL reset_ra3: got %0d want 0", ra3); end
    n_cmp++; if (wd3 !== '0)        begin n_bad++; $display("FAIL reset_wd3: got %h want 0", wd3); end
    n_cmp++; if (err_addr !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_addr); end
    n_cmp++; if (busy1 !== 1'b0)    begin n_bad++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
      begin n_bad++; $display("FAIL reset_ready: got mem=%b alu=%b want 1/1", mem_ready, alu_ready); end
    next_cycle(); rst = 1'b0;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 24'h00ABCD; ra1 = 4'd3;
    @(negedge clk);
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    n_cmp++; if (busy1 !== 1'b0)     begin n_bad++; $display("FAIL single_busy_n: got %b want 0", busy1); end
    next_cycle(); alu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (we3 !== 1'b0)   begin n_bad++; $display("FAIL single_we3_n1: got %b want 0", we3); end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL single_busy_n1: got %b want 1", busy1); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b1 || ra3 !== 4'd3 || wd3 !== 24'h00ABCD)
      begin n_bad++; $display("FAIL single_write_n2: got we=%b ra=%0d wd=%h want 1/3/00abcd", we3, ra3, wd3); end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL single_busy_n2: got %b want 1", busy1); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b0)   begin n_bad++; $display("FAIL single_we3_n3: got %b want 0", we3); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL single_busy_n3: got %b want 0", busy1); end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 24'h111111;
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 24'h222222; ra2 = 4'd5;
    @(negedge clk);
    n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1)
      begin n_bad++; $display("FAIL simul_ready: got mem=%b alu=%b want 1/1", mem_ready, alu_ready); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    n_cmp++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL simul_busy2: got %b want 1", busy2); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b1 || ra3 !== 4'd5 || wd3 !== 24'h111111)
      begin n_bad++; $display("FAIL simul_first: got we=%b ra=%0d wd=%h want 1/5/111111", we3, ra3, wd3); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b1 || ra3 !== 4'd5 || wd3 !== 24'h222222)
      begin n_bad++; $display("FAIL simul_second: got we=%b ra=%0d wd=%h want 1/5/222222", we3, ra3, wd3); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b0 || wd3 !== 24'h222222 || busy2 !== 1'b0)
      begin n_bad++; $display("FAIL simul_final: got we=%b wd=%h busy2=%b want 0/222222/0", we3, wd3, busy2); end
  endtask

  // Both producers offer continuously; because the queue drains every cycle
  // and no pop credit is given, the ALU side sees back-pressure.
  task automatic test_back_pressure();
    ent_t mem_e[6], alu_e[6];
    ent_t exp_q[$], got_q[$];
    int mi = 0, ai = 0, cyc = 0;
    bit saw_stall = 1'b0;
    logic e_mr, e_ar;
    for (int i = 0; i < 6; i++) begin
      mem_e[i] = '{ADDR_W'(i),     DATA_W'(24'hA00000 + i)};
      alu_e[i] = '{ADDR_W'(6 + i), DATA_W'(24'hB00000 + i)};
    end
    for (cyc = 0; cyc < 100 && (mi < 6 || ai < 6 || m_q.size() > 0); cyc++) begin
      next_cycle();
      mem_valid = (mi < 6); alu_valid = (ai < 6);
      if (mi < 6) begin mem_rd = mem_e[mi].rd; mem_data = mem_e[mi].data; end
      if (ai < 6) begin alu_rd = alu_e[ai].rd; alu_data = alu_e[ai].data; end
      @(negedge clk);
      if (we3) got_q.push_back('{ra3, wd3});
      e_mr = f_mem_ready(); e_ar = f_alu_ready();
      n_cmp++; if (mem_ready !== e_mr || alu_ready !== e_ar)
        begin n_bad++; $display("FAIL bp_ready: got mem=%b alu=%b want %b/%b", mem_ready, alu_ready, e_mr, e_ar); end
      if (alu_valid && !e_ar) saw_stall = 1'b1;
      if (mem_valid && e_mr) begin exp_q.push_back(mem_e[mi]); mi++; end
      if (alu_valid && e_ar) begin exp_q.push_back(alu_e[ai]); ai++; end
    end
    idle_inputs();
    n_cmp++; if (cyc >= 100) begin n_bad++; $display("FAIL bp_timeout: got %0d cycles want <100", cyc); end
    n_cmp++; if (saw_stall !== 1'b1) begin n_bad++; $display("FAIL bp_stall: got %b want 1", saw_stall); end
    n_cmp++; if (got_q.size() != 12) begin n_bad++; $display("FAIL bp_count: got %0d want 12", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].rd !== exp_q[i].rd || got_q[i].data !== exp_q[i].data)
        begin n_bad++; $display("FAIL bp_order[%0d]: got %0d/%h want %0d/%h", i, got_q[i].rd, got_q[i].data, exp_q[i].rd, exp_q[i].data); end
    end
  endtask

  task automatic test_flush();
    next_cycle();
    mem_valid = 1'b1; mem_rd = 4'd1; mem_data = 24'h010101;
    alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 24'h020202;
    next_cycle();
    mem_rd = 4'd3; mem_data = 24'h030303; alu_rd = 4'd4; alu_data = 24'h040404;
    next_cycle();
    flush = 1'b1; mem_rd = 4'd7; alu_rd = 4'd7; ra1 = 4'd3; ra2 = 4'd4;
    @(negedge clk);
    n_cmp++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0)
      begin n_bad++; $display("FAIL flush_ready: got mem=%b alu=%b want 0/0", mem_ready, alu_ready); end
    n_cmp++; if (busy1 !== 1'b1 || busy2 !== 1'b1)
      begin n_bad++; $display("FAIL flush_busy_pre: got %b/%b want 1/1", busy1, busy2); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    n_cmp++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL flush_we3: got %b want 0", we3); end
    n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0)
      begin n_bad++; $display("FAIL flush_busy_post: got %b/%b want 0/0", busy1, busy2); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); @(negedge clk);
      n_cmp++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL flush_stale[%0d]: got %b want 0", i, we3); end
    end
  endtask

  task automatic test_reset_during_push();
    next_cycle();
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 24'h080808;
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 24'h090909;
    next_cycle();
    rst = 1'b1; mem_valid = 1'b0; alu_rd = 4'd10; ra1 = 4'd8; ra2 = 4'd9;
    next_cycle();
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    n_cmp++; if (we3 !== 1'b0 || wd3 !== '0 || ra3 !== '0)
      begin n_bad++; $display("FAIL rstpush_port: got we=%b ra=%0d wd=%h want 0/0/0", we3, ra3, wd3); end
    n_cmp++; if (busy1 !== 1'b0 || busy2 !== 1'b0)
      begin n_bad++; $display("FAIL rstpush_busy: got %b/%b want 0/0", busy1, busy2); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); @(negedge clk);
      n_cmp++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL rstpush_write[%0d]: got %b want 0", i, we3); end
    end
  endtask

  task automatic test_invalid_index();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 4'd13; alu_data = 24'h131313; ra1 = 4'd13;
    @(negedge clk);
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL inval_ready: got %b want 1", alu_ready); end
    n_cmp++; if (err_addr !== 1'b0)  begin n_bad++; $display("FAIL inval_err_pre: got %b want 0", err_addr); end
    next_cycle(); idle_inputs();
    @(negedge clk);
    n_cmp++; if (err_addr !== 1'b1) begin n_bad++; $display("FAIL inval_err: got %b want 1", err_addr); end
    n_cmp++; if (busy1 !== 1'b0)    begin n_bad++; $display("FAIL inval_busy: got %b want 0", busy1); end
    next_cycle(); @(negedge clk);
    n_cmp++; if (we3 !== 1'b0) begin n_bad++; $display("FAIL inval_we3: got %b want 0", we3); end
    next_cycle(); flush = 1'b1;
    next_cycle(); flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_addr !== 1'b1) begin n_bad++; $display("FAIL inval_flush_err: got %b want 1", err_addr); end
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (err_addr !== 1'b0) begin n_bad++; $display("FAIL inval_rst_err: got %b want 0", err_addr); end
  endtask

  task automatic test_random();
    logic e_mr, e_ar, e_b1, e_b2;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      mem_valid = $urandom_range(0, 1);
      alu_valid = $urandom_range(0, 1);
      mem_rd    = ($urandom_range(0, 14) == 0) ? ADDR_W'($urandom_range(12, 15)) : ADDR_W'($urandom_range(0, 11));
      alu_rd    = ($urandom_range(0, 14) == 0) ? ADDR_W'($urandom_range(12, 15)) : ADDR_W'($urandom_range(0, 11));
      mem_data  = DATA_W'($urandom);
      alu_data  = DATA_W'($urandom);
      ra1       = ADDR_W'($urandom_range(0, 15));
      ra2       = ADDR_W'($urandom_range(0, 15));
      @(negedge clk);
      e_mr = f_mem_ready(); e_ar = f_alu_ready(); e_b1 = f_busy(ra1); e_b2 = f_busy(ra2);
      n_cmp++; if (mem_ready !== e_mr) begin n_bad++; $display("FAIL rnd_mem_ready@%0d: got %b want %b", c, mem_ready, e_mr); end
      n_cmp++; if (alu_ready !== e_ar) begin n_bad++; $display("FAIL rnd_alu_ready@%0d: got %b want %b", c, alu_ready, e_ar); end
      n_cmp++; if (busy1 !== e_b1)     begin n_bad++; $display("FAIL rnd_busy1@%0d: got %b want %b", c, busy1, e_b1); end
      n_cmp++; if (busy2 !== e_b2)     begin n_bad++; $display("FAIL rnd_busy2@%0d: got %b want %b", c, busy2, e_b2); end
      n_cmp++; if (we3 !== m_we)       begin n_bad++; $display("FAIL rnd_we3@%0d: got %b want %b", c, we3, m_we); end
      n_cmp++; if (ra3 !== m_ra)       begin n_bad++; $display("FAIL rnd_ra3@%0d: got %0d want %0d", c, ra3, m_ra); end
      n_cmp++; if (wd3 !== m_wd)       begin n_bad++; $display("FAIL rnd_wd3@%0d: got %h want %h", c, wd3, m_wd); end
      n_cmp++; if (err_addr !== m_err) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, err_addr, m_err); end
    end
    next_cycle(); rst = 1'b0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_back_pressure();
    test_flush();
    test_reset_during_push();
    test_invalid_index();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
